hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Tuse/Tnew-based hazard and forwarding controller for the five-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Tracks destination register and remaining Tnew of the instructions in EX, MEM and WB in internal shadow registers.
- Issues the ID stall plus forwarding selects for the ID and EX operand muxes.
- Owns the mult/div busy counter with configurable latencies, so HI/LO users stall locally without an external Busy/Start.

Parameters:
- A_W, 5, register address width (2**A_W architectural registers; register 0 is hardwired zero).
- MULT_CYCLES, 5, busy cycles for mult/multu (at least 1).
- DIV_CYCLES, 10, busy cycles for div/divu (at least 1).
- CNT_W, 4, busy counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID holds a real instruction; 0 means bubble.
- id_rs, id_rt  in  A_W  source register numbers in ID.
- id_tuse_rs, id_tuse_rt  in  2  cycles from ID until the operand is needed: 0=ID (branch/jr), 1=EX, 2=MEM (store data), 3=not used.
- id_regwrite  in  1  instruction writes the GPR file.
- id_a3  in  A_W  destination register.
- id_tnew  in  2  cycles after entering EX until the result exists: 0=jal/link, 1=ALU/mfhi, 2=load.
- id_md_use  in  1  instruction uses the mult/div unit (mult/div/mfhi/mflo/mthi/mtlo).
- id_md_start  in  1  instruction starts mult/div.
- id_md_is_div  in  1  started operation is a divide.
- stall  out  1  hold PC and IF/ID; insert bubble into EX.
- fwd_rs_id, fwd_rt_id  out  2  ID operand source: 0=regfile, 1=EX, 2=MEM, 3=WB.
- fwd_rs_ex, fwd_rt_ex  out  2  EX operand source: 0=latched, 2=MEM, 3=WB (1 never driven).
- md_busy  out  1  mult/div unit busy.

Behaviour:
- Shadow state:
  - EX: we, a3, tnew, rs, rt.
  - MEM: we, a3, tnew.
  - WB: we, a3.
  - Busy counter: md_cnt.
- Reset: all shadow registers and md_cnt are 0. The next cycle, md_busy=0; stall and the fwd outputs depend only on the current inputs (all fwd outputs 0).
- Each rising edge without reset:
  - WB <= MEM.
  - MEM <= EX, with mem_tnew = ex_tnew-1 saturating at 0.
  - If stall=1 or id_valid=0, EX <= bubble (we=0, a3=0, tnew=0).
  - Otherwise EX <= ID fields, with we = id_regwrite && id_a3!=0.
  - Downstream stages never stall.
- Hazard per source s in {rs, rt}: only when id_valid, s!=0 and tuse!=3.
  - stall_s = (ex_we && ex_a3==s && ex_tnew>tuse) || (mem_we && mem_a3==s && mem_tnew>tuse).
- MDU stall: id_valid && id_md_use && md_busy.
- stall = OR of all hazard terms and the MDU stall. It is combinational, with zero latency from ID inputs.
- ID forwarding: the first match in order EX, MEM, WB wins.
  - A stage matches when we=1, a3==s, s!=0 and tnew==0 (WB always has tnew 0).
  - No match gives 0.
- EX forwarding: same rule using ex_rs/ex_rt against MEM then WB; EX-stage register 0 gives 0.
- Busy counter:
  - On an edge where id_valid && id_md_start && !stall, md_cnt <= DIV_CYCLES if id_md_is_div, else MULT_CYCLES.
  - Otherwise, if md_cnt != 0, md_cnt decrements by 1.
  - md_busy = (md_cnt != 0), so it is high for exactly N consecutive cycles starting the cycle after issue.
- Boundary rules:
  - A stalled md_start does not load the counter.
  - A new start cannot issue while busy, because it is itself an md_use and stalls.
  - Reset mid-divide clears md_cnt immediately.
  - With the same destination in EX and MEM, the EX entry governs both stall and forwarding.
  - id_valid=0 forces stall=0.

Test Plan:
- ALU-to-branch: EX holds addu $8 (tnew 1); ID has beq with rs=$8, tuse 0 -> stall=1 for one cycle. The next cycle has $8 in MEM with tnew 0 -> stall=0, fwd_rs_id=2.
- Load-use: lw $9 in EX (tnew 2); ID addu with rt=$9, tuse 1 -> stall=1 for one cycle. Then $9 is in MEM with tnew 1 -> stall=0. Next cycle: fwd_rt_ex=3 (WB).
- Store data: lw $9 in EX; ID sw with rt=$9, tuse 2 -> no stall. When the sw reaches EX: fwd_rt_ex=2 is not yet valid because tnew is 1. One cycle later: fwd_rt_ex=3.
- Register 0: ID addu rs=$0 with EX lw a3=$0 -> stall=0, all fwd outputs 0.
- Divide: div issues at cycle t with DIV_CYCLES=10 -> md_busy high for cycles t+1..t+10. A following mflo stalls through t+10 and issues at t+11. An unrelated addu is not stalled.
- Reset at cycle t+4 of a divide -> md_busy=0 and stall=0 the next cycle; all shadow registers 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Hazard and forwarding controller for the five-stage MIPS pipeline,
// driven by Tuse/Tnew. Shadow registers track the destination and the
// remaining Tnew of the instructions in EX, MEM and WB. From these the
// block derives the ID stall and the forwarding selects for the ID and EX
// operand muxes. It also owns the mult/div busy counter, so HI/LO users
// stall here and no external Busy/Start handshake is needed.
module hazard_scoreboard #(
  parameter int A_W         = 5,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           id_valid,
  input  logic [A_W-1:0] id_rs,
  input  logic [A_W-1:0] id_rt,
  input  logic [1:0]     id_tuse_rs,
  input  logic [1:0]     id_tuse_rt,
  input  logic           id_regwrite,
  input  logic [A_W-1:0] id_a3,
  input  logic [1:0]     id_tnew,
  input  logic           id_md_use,
  input  logic           id_md_start,
  input  logic           id_md_is_div,
  output logic           stall,
  output logic [1:0]     fwd_rs_id,
  output logic [1:0]     fwd_rt_id,
  output logic [1:0]     fwd_rs_ex,
  output logic [1:0]     fwd_rt_ex,
  output logic           md_busy
);

  // Operand source encoding shared by the ID and EX forwarding muxes.
  typedef enum logic [1:0] {
    SRC_RF  = 2'd0,
    SRC_EX  = 2'd1,
    SRC_MEM = 2'd2,
    SRC_WB  = 2'd3
  } fwd_src_e;

  localparam logic [1:0]       TUSE_NONE = 2'd3;
  localparam logic [A_W-1:0]   REG_ZERO  = '0;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  // Pipeline shadow state.
  logic           ex_we,  mem_we,  wb_we;
  logic [A_W-1:0] ex_a3,  mem_a3,  wb_a3;
  logic [1:0]     ex_tnew, mem_tnew;
  logic [A_W-1:0] ex_rs,  ex_rt;
  logic [CNT_W-1:0] md_cnt;

  logic rs_hazard, rt_hazard, md_hazard;
  logic md_load;

  // One source operand in ID against the in-flight producers. When EX and
  // MEM both write this register, the younger EX entry is the value the
  // consumer really needs, so the MEM entry is ignored for that register.
  function automatic logic src_hazard(
    input logic           valid,
    input logic [A_W-1:0] src,
    input logic [1:0]     tuse,
    input logic           e_we,
    input logic [A_W-1:0] e_a3,
    input logic [1:0]     e_tnew,
    input logic           m_we,
    input logic [A_W-1:0] m_a3,
    input logic [1:0]     m_tnew
  );
    logic e_hit;
    logic m_hit;
    e_hit = e_we && (e_a3 == src);
    m_hit = m_we && (m_a3 == src);
    if (!valid || (src == REG_ZERO) || (tuse == TUSE_NONE))
      return 1'b0;
    if (e_hit)
      return e_tnew > tuse;
    return m_hit && (m_tnew > tuse);
  endfunction

  // Forwarding source for one operand: the youngest stage that already
  // holds the finished value wins (EX, then MEM, then WB). WB results are
  // always finished, so WB needs no Tnew check.
  function automatic logic [1:0] fwd_pick(
    input logic [A_W-1:0] src,
    input logic           e_we,
    input logic [A_W-1:0] e_a3,
    input logic [1:0]     e_tnew,
    input logic           m_we,
    input logic [A_W-1:0] m_a3,
    input logic [1:0]     m_tnew,
    input logic           w_we,
    input logic [A_W-1:0] w_a3
  );
    fwd_src_e sel;
    sel = SRC_RF;
    if (src != REG_ZERO) begin
      if (e_we && (e_a3 == src) && (e_tnew == 2'd0))
        sel = SRC_EX;
      else if (m_we && (m_a3 == src) && (m_tnew == 2'd0))
        sel = SRC_MEM;
      else if (w_we && (w_a3 == src))
        sel = SRC_WB;
    end
    return sel;
  endfunction

  // Combinational stall: register hazards on either source plus any
  // mult/div user that arrives while the unit is still busy.
  always_comb begin
    // NOTE: every signal driven here receives a value on every path, which
    // keeps this a pure mux tree with no inferred latches.
    rs_hazard = src_hazard(id_valid, id_rs, id_tuse_rs, ex_we, ex_a3, ex_tnew,
                           mem_we, mem_a3, mem_tnew);
    rt_hazard = src_hazard(id_valid, id_rt, id_tuse_rt, ex_we, ex_a3, ex_tnew,
                           mem_we, mem_a3, mem_tnew);
    md_hazard = id_valid && id_md_use && md_busy;
    stall     = rs_hazard || rt_hazard || md_hazard;
    md_load   = id_valid && id_md_start && !stall;
  end

  // Forwarding selects. EX operands can only take values from MEM or WB,
  // so the EX-stage lookup is given a permanently empty EX slot.
  always_comb begin
    fwd_rs_id = fwd_pick(id_rs, ex_we, ex_a3, ex_tnew, mem_we, mem_a3,
                         mem_tnew, wb_we, wb_a3);
    fwd_rt_id = fwd_pick(id_rt, ex_we, ex_a3, ex_tnew, mem_we, mem_a3,
                         mem_tnew, wb_we, wb_a3);
    fwd_rs_ex = fwd_pick(ex_rs, 1'b0, REG_ZERO, 2'd0, mem_we, mem_a3,
                         mem_tnew, wb_we, wb_a3);
    fwd_rt_ex = fwd_pick(ex_rt, 1'b0, REG_ZERO, 2'd0, mem_we, mem_a3,
                         mem_tnew, wb_we, wb_a3);
  end

  // Shadow pipeline: EX takes ID or a bubble, MEM and WB always advance.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the values its predecessor held before this edge.
    if (reset) begin
      ex_we    <= 1'b0;
      ex_a3    <= '0;
      ex_tnew  <= 2'd0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      mem_we   <= 1'b0;
      mem_a3   <= '0;
      mem_tnew <= 2'd0;
      wb_we    <= 1'b0;
      wb_a3    <= '0;
    end else begin
      wb_we    <= mem_we;
      wb_a3    <= mem_a3;
      mem_we   <= ex_we;
      mem_a3   <= ex_a3;
      mem_tnew <= (ex_tnew == 2'd0) ? 2'd0 : ex_tnew - 2'd1;
      if (stall || !id_valid) begin
        ex_we   <= 1'b0;
        ex_a3   <= '0;
        ex_tnew <= 2'd0;
        ex_rs   <= '0;
        ex_rt   <= '0;
      end else begin
        ex_we   <= id_regwrite && (id_a3 != REG_ZERO);
        ex_a3   <= id_a3;
        ex_tnew <= id_tnew;
        ex_rs   <= id_rs;
        ex_rt   <= id_rt;
      end
    end
  end

  // Mult/div busy counter: loaded by an issuing start, then counts down.
  always_ff @(posedge clk) begin
    if (reset)
      md_cnt <= '0;
    else if (md_load)
      md_cnt <= id_md_is_div ? DIV_LOAD : MULT_LOAD;
    else if (md_cnt != '0)
      md_cnt <= md_cnt - 1'b1;
  end

  assign md_busy = (md_cnt != '0);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
// Directed bench for hazard_scoreboard. It drives instruction fields into ID
// one cycle at a time and compares stall, forwarding and md_busy against
// values worked out by hand from the Tuse/Tnew rules.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_a3;
  logic [1:0] id_tuse_rs, id_tuse_rt, id_tnew;
  logic       id_regwrite, id_md_use, id_md_start, id_md_is_div;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_id, fwd_rt_id, fwd_rs_ex, fwd_rt_ex;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard #(
    .A_W(5), .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_tuse_rs(id_tuse_rs), .id_tuse_rt(id_tuse_rt),
    .id_regwrite(id_regwrite), .id_a3(id_a3), .id_tnew(id_tnew),
    .id_md_use(id_md_use), .id_md_start(id_md_start),
    .id_md_is_div(id_md_is_div),
    .stall(stall), .fwd_rs_id(fwd_rs_id), .fwd_rt_id(fwd_rt_id),
    .fwd_rs_ex(fwd_rs_ex), .fwd_rt_ex(fwd_rt_ex), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [1:0] trs, input logic [1:0] trt,
                        input logic rw, input logic [4:0] a3, input logic [1:0] tnew,
                        input logic mu, input logic ms, input logic md);
    id_valid = v;  id_rs = rs;  id_rt = rt;
    id_tuse_rs = trs;  id_tuse_rt = trt;
    id_regwrite = rw;  id_a3 = a3;  id_tnew = tnew;
    id_md_use = mu;  id_md_start = ms;  id_md_is_div = md;
    #1;
  endtask

  task automatic bubble();
    set_id(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one clock and step just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    bubble();
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b1;
    bubble();
    repeat (2) tick();
    reset = 1'b0;
    #1;

    // Reset state
    check("rst_md_busy", md_busy, 0);
    check("rst_stall", stall, 0);
    check("rst_fwd_rs_id", fwd_rs_id, 0);
    check("rst_fwd_rt_ex", fwd_rt_ex, 0);
    set_id(1, 5'd8, 5'd9, 2'd0, 2'd0, 1, 5'd10, 2'd1, 0, 0, 0);
    check("rst_empty_no_stall", stall, 0);
    flush();

    // ALU result feeding a branch
    set_id(1, 5'd1, 5'd2, 2'd1, 2'd1, 1, 5'd8, 2'd1, 0, 0, 0);   // addu $8
    check("alu_issue", stall, 0);
    tick();
    set_id(1, 5'd8, 5'd0, 2'd0, 2'd0, 0, 5'd0, 2'd0, 0, 0, 0);   // beq $8
    check("alu_br_stall", stall, 1);
    tick();
    check("alu_br_release", stall, 0);
    check("alu_br_fwd_rs_id", fwd_rs_id, 2);
    tick();
    check("alu_br_fwd_rs_ex", fwd_rs_ex, 3);
    check("alu_br_fwd_rt_ex", fwd_rt_ex, 0);
    flush();

    // Load-use
    set_id(1, 5'd4, 5'd0, 2'd1, 2'd3, 1, 5'd9, 2'd2, 0, 0, 0);   // lw $9
    tick();
    set_id(1, 5'd5, 5'd9, 2'd1, 2'd1, 1, 5'd10, 2'd1, 0, 0, 0);  // addu rt=$9
    check("lu_stall", stall, 1);
    id_valid = 1'b0;
    #1;
    check("lu_invalid_no_stall", stall, 0);
    id_valid = 1'b1;
    #1;
    tick();
    check("lu_release", stall, 0);
    check("lu_fwd_rt_id", fwd_rt_id, 0);
    tick();
    check("lu_fwd_rt_ex", fwd_rt_ex, 3);
    check("lu_fwd_rs_ex", fwd_rs_ex, 0);
    flush();

    // Store data after a load
    set_id(1, 5'd4, 5'd0, 2'd1, 2'd3, 1, 5'd9, 2'd2, 0, 0, 0);   // lw $9
    tick();
    set_id(1, 5'd4, 5'd9, 2'd1, 2'd2, 0, 5'd0, 2'd0, 0, 0, 0);   // sw rt=$9
    check("st_no_stall", stall, 0);
    tick();
    check("st_fwd_rt_ex_early", fwd_rt_ex, 0);
    set_id(1, 5'd4, 5'd9, 2'd1, 2'd2, 0, 5'd0, 2'd0, 0, 0, 0);   // second sw
    check("st2_no_stall", stall, 0);
    check("st2_fwd_rt_id", fwd_rt_id, 0);
    tick();
    check("st2_fwd_rt_ex", fwd_rt_ex, 3);
    flush();

    // Register 0 never creates a dependency
    set_id(1, 5'd4, 5'd0, 2'd1, 2'd3, 1, 5'd0, 2'd2, 0, 0, 0);   // lw $0
    tick();
    set_id(1, 5'd0, 5'd0, 2'd1, 2'd1, 1, 5'd10, 2'd1, 0, 0, 0);
    check("r0_stall", stall, 0);
    check("r0_fwd_rs_id", fwd_rs_id, 0);
    check("r0_fwd_rt_id", fwd_rt_id, 0);
    tick();
    check("r0_fwd_rs_ex", fwd_rs_ex, 0);
    check("r0_fwd_rt_ex", fwd_rt_ex, 0);
    flush();

    // Same destination in EX and MEM: the EX entry wins
    set_id(1, 5'd4, 5'd0, 2'd1, 2'd3, 1, 5'd31, 2'd2, 0, 0, 0);  // lw $31
    tick();
    set_id(1, 5'd0, 5'd0, 2'd3, 2'd3, 1, 5'd31, 2'd0, 0, 0, 0);  // jal
    check("dup_jal_no_stall", stall, 0);
    tick();
    set_id(1, 5'd31, 5'd0, 2'd0, 2'd3, 0, 5'd0, 2'd0, 0, 0, 0);  // jr $31
    check("dup_jr_stall", stall, 0);
    check("dup_jr_fwd_rs_id", fwd_rs_id, 1);
    flush();

    // Stalled mult start does not load the counter
    set_id(1, 5'd4, 5'd0, 2'd1, 2'd3, 1, 5'd9, 2'd2, 0, 0, 0);   // lw $9
    tick();
    set_id(1, 5'd9, 5'd0, 2'd1, 2'd1, 0, 5'd0, 2'd0, 1, 1, 0);   // mult $9
    check("mult_lu_stall", stall, 1);
    tick();
    check("mult_no_load_busy", md_busy, 0);
    check("mult_release", stall, 0);
    tick();
    bubble();
    for (int i = 0; i < 5; i++) begin
      check("mult_busy", md_busy, 1);
      tick();
    end
    check("mult_done", md_busy, 0);
    flush();

    // Divide followed by mflo
    set_id(1, 5'd1, 5'd2, 2'd1, 2'd1, 0, 5'd0, 2'd0, 1, 1, 1);   // div
    check("div_issue_stall", stall, 0);
    check("div_issue_busy", md_busy, 0);
    tick();
    set_id(1, 5'd1, 5'd2, 2'd1, 2'd1, 1, 5'd3, 2'd1, 0, 0, 0);   // unrelated addu
    check("div_addu_no_stall", stall, 0);
    set_id(1, 5'd0, 5'd0, 2'd3, 2'd3, 1, 5'd3, 2'd1, 1, 0, 0);   // mflo
    for (int i = 1; i <= 10; i++) begin
      check("div_busy", md_busy, 1);
      check("div_mflo_stall", stall, 1);
      tick();
    end
    check("div_done_busy", md_busy, 0);
    check("div_mflo_issue", stall, 0);
    tick();
    check("mflo_no_restart", md_busy, 0);
    flush();

    // Reset in the middle of a divide
    set_id(1, 5'd1, 5'd2, 2'd1, 2'd1, 0, 5'd0, 2'd0, 1, 1, 1);   // div at t
    tick();
    bubble();
    tick();
    set_id(1, 5'd1, 5'd2, 2'd1, 2'd1, 1, 5'd8, 2'd1, 0, 0, 0);   // addu $8
    tick();
    tick();
    check("rstdiv_busy_before", md_busy, 1);
    set_id(1, 5'd8, 5'd0, 2'd0, 2'd3, 0, 5'd0, 2'd0, 0, 0, 0);   // beq $8
    check("rstdiv_stall_before", stall, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rstdiv_busy_after", md_busy, 0);
    check("rstdiv_stall_after", stall, 0);
    check("rstdiv_fwd_rs_id", fwd_rs_id, 0);
    set_id(1, 5'd0, 5'd0, 2'd3, 2'd3, 1, 5'd3, 2'd1, 1, 0, 0);   // mflo
    check("rstdiv_mflo_stall", stall, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
